// File: rtl/pkg_link_writer_pkg.sv
// Shared definitions for the linked-list packet buffer: writer state encoding,
// page geometry helpers and the end-of-chain link convention.
package pkg_link_writer_pkg;

    typedef enum logic [1:0] {
        LW_IDLE   = 2'd0,
        LW_WRITE  = 2'd1,
        LW_NEXT   = 2'd2,
        LW_COMMIT = 2'd3
    } lw_state_t;

    function automatic int offset_width(input int addr_width, input int page_num_log);
        return addr_width - page_num_log;
    endfunction

    function automatic int page_words(input int addr_width, input int page_num_log);
        return 1 << offset_width(addr_width, page_num_log);
    endfunction

    // The last page of a packet links to itself.
    function automatic logic [31:0] link_end(input logic [31:0] page);
        return page;
    endfunction

    function automatic logic is_link_end(input logic [31:0] page, input logic [31:0] next_page);
        return page == next_page;
    endfunction

endpackage

// File: rtl/pkg_link_writer_offset.sv
// Word offset within the current page; wrap flags the last word of a page.
module page_offset_counter #(
    parameter int OFFSET_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_clr,
    input  logic                    i_inc,
    output logic [OFFSET_WIDTH-1:0] o_offset,
    output logic                    o_wrap
);

    logic [OFFSET_WIDTH-1:0] r_offset;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_offset <= '0;
        end else if (i_clr) begin
            r_offset <= '0;
        end else if (i_inc) begin
            r_offset <= r_offset + 1'b1;
        end
    end

    assign o_offset = r_offset;
    assign o_wrap   = &r_offset;

endmodule

// File: rtl/pkg_link_writer.sv
// Producer side of the linked-list packet buffer: fills pages from the free
// table, chains them in the link RAM and hands the head page to the data table.
module pkg_link_writer
    import pkg_link_writer_pkg::*;
#(
    parameter int ADDR_WIDTH        = 8,
    parameter int ADDR_PAGE_NUM_LOG = 4,
    parameter int DATA_WIDTH        = 16,
    parameter int LEN_WIDTH         = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_WIDTH-1:0]        in_data,
    input  logic                         in_last,
    output logic                         free_table_read_req,
    input  logic [ADDR_PAGE_NUM_LOG-1:0] free_table_read_addr,
    input  logic                         free_table_empty,
    output logic                         data_table_write_req,
    output logic [ADDR_PAGE_NUM_LOG-1:0] data_table_write_addr,
    output logic                         ram_write_en,
    output logic [ADDR_WIDTH-1:0]        ram_write_addr,
    output logic [DATA_WIDTH-1:0]        ram_write_data,
    output logic                         link_write_en,
    output logic [ADDR_PAGE_NUM_LOG-1:0] link_write_addr,
    output logic [ADDR_PAGE_NUM_LOG-1:0] link_write_data,
    output logic                         pkt_done,
    output logic [LEN_WIDTH-1:0]         pkt_word_cnt
);

    localparam int OFFSET_WIDTH = offset_width(ADDR_WIDTH, ADDR_PAGE_NUM_LOG);

    lw_state_t                      r_state;
    lw_state_t                      w_state_next;
    logic [ADDR_PAGE_NUM_LOG-1:0]   r_head_page;
    logic [ADDR_PAGE_NUM_LOG-1:0]   r_cur_page;
    logic [LEN_WIDTH-1:0]           r_cnt;
    logic [LEN_WIDTH-1:0]           r_pkt_word_cnt;
    logic [OFFSET_WIDTH-1:0]        w_offset;
    logic                           w_wrap;
    logic                           w_off_clr;
    logic                           w_off_inc;

    page_offset_counter #(
        .OFFSET_WIDTH(OFFSET_WIDTH)
    ) u_offset (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (w_off_clr),
        .i_inc    (w_off_inc),
        .o_offset (w_offset),
        .o_wrap   (w_wrap)
    );

    always_comb begin
        w_state_next          = r_state;
        w_off_clr             = 1'b0;
        w_off_inc             = 1'b0;
        in_ready              = 1'b0;
        free_table_read_req   = 1'b0;
        data_table_write_req  = 1'b0;
        data_table_write_addr = '0;
        ram_write_en          = 1'b0;
        link_write_en         = 1'b0;
        link_write_addr       = '0;
        link_write_data       = '0;
        pkt_done              = 1'b0;
        case (r_state)
            LW_IDLE: begin
                if (in_valid && !free_table_empty) begin
                    free_table_read_req = 1'b1;
                    w_off_clr           = 1'b1;
                    w_state_next        = LW_WRITE;
                end
            end
            LW_WRITE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    ram_write_en = 1'b1;
                    // A packet ending on the last word of a page commits
                    // directly, so no trailing empty page is allocated.
                    if (in_last) begin
                        w_off_clr    = 1'b1;
                        w_state_next = LW_COMMIT;
                    end else if (w_wrap) begin
                        w_off_clr    = 1'b1;
                        w_state_next = LW_NEXT;
                    end else begin
                        w_off_inc = 1'b1;
                    end
                end
            end
            LW_NEXT: begin
                if (!free_table_empty) begin
                    free_table_read_req = 1'b1;
                    link_write_en       = 1'b1;
                    link_write_addr     = r_cur_page;
                    link_write_data     = free_table_read_addr;
                    w_state_next        = LW_WRITE;
                end
            end
            LW_COMMIT: begin
                link_write_en         = 1'b1;
                link_write_addr       = r_cur_page;
                link_write_data       = ADDR_PAGE_NUM_LOG'(link_end(32'(r_cur_page)));
                data_table_write_req  = 1'b1;
                data_table_write_addr = r_head_page;
                pkt_done              = 1'b1;
                w_state_next          = LW_IDLE;
            end
            default: w_state_next = LW_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= LW_IDLE;
            r_head_page    <= '0;
            r_cur_page     <= '0;
            r_cnt          <= '0;
            r_pkt_word_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                LW_IDLE: begin
                    if (in_valid && !free_table_empty) begin
                        r_head_page <= free_table_read_addr;
                        r_cur_page  <= free_table_read_addr;
                        r_cnt       <= '0;
                    end
                end
                LW_WRITE: begin
                    if (in_valid && (r_cnt != '1)) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                LW_NEXT: begin
                    if (!free_table_empty) begin
                        r_cur_page <= free_table_read_addr;
                    end
                end
                LW_COMMIT: r_pkt_word_cnt <= r_cnt;
                default: ;
            endcase
        end
    end

    assign ram_write_addr = {r_cur_page, w_offset};
    assign ram_write_data = in_data;
    assign pkt_word_cnt   = r_pkt_word_cnt;

endmodule

// File: tb/tb_pkg_link_writer.sv
// Self-checking bench for pkg_link_writer with a queue-style free-table model
// and an arithmetic page-layout reference.
module tb_pkg_link_writer;

    localparam int AW = 6;
    localparam int PL = 4;
    localparam int DW = 16;
    localparam int LW = 16;
    localparam int PW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic          free_table_read_req;
    logic [PL-1:0] free_table_read_addr;
    logic          free_table_empty;
    logic          data_table_write_req;
    logic [PL-1:0] data_table_write_addr;
    logic          ram_write_en;
    logic [AW-1:0] ram_write_addr;
    logic [DW-1:0] ram_write_data;
    logic          link_write_en;
    logic [PL-1:0] link_write_addr;
    logic [PL-1:0] link_write_data;
    logic          pkt_done;
    logic [LW-1:0] pkt_word_cnt;

    always #5 clk = ~clk;

    pkg_link_writer #(
        .ADDR_WIDTH(AW), .ADDR_PAGE_NUM_LOG(PL), .DATA_WIDTH(DW), .LEN_WIDTH(LW)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .free_table_read_req(free_table_read_req),
        .free_table_read_addr(free_table_read_addr),
        .free_table_empty(free_table_empty),
        .data_table_write_req(data_table_write_req),
        .data_table_write_addr(data_table_write_addr),
        .ram_write_en(ram_write_en), .ram_write_addr(ram_write_addr),
        .ram_write_data(ram_write_data),
        .link_write_en(link_write_en), .link_write_addr(link_write_addr),
        .link_write_data(link_write_data),
        .pkt_done(pkt_done), .pkt_word_cnt(pkt_word_cnt)
    );

    // Free-table model: FIFO of pages with monotonic head/tail pointers.
    logic [PL-1:0] ft_pages [0:255];
    logic [7:0]    ft_head = '0;
    logic [7:0]    ft_tail = '0;
    logic [7:0]    ft_resync_to = '0;
    logic          ft_resync = 1'b0;
    logic          force_empty = 1'b0;
    int            pops = 0;
    int            cyc = 0;

    assign free_table_empty     = force_empty || (ft_head == ft_tail);
    assign free_table_read_addr = ft_pages[ft_head];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ft_resync) begin
            ft_head <= ft_resync_to;
        end else if (free_table_read_req && !free_table_empty) begin
            ft_head <= ft_head + 8'd1;
            pops    <= pops + 1;
        end
    end

    typedef struct { int addr; int data; int cyc; } ram_ev_t;
    typedef struct { int a; int d; } link_ev_t;
    ram_ev_t  ram_log[$];
    link_ev_t link_log[$];
    int       dt_log[$];
    int       done_n = 0;
    int       bad_pop_n = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (ram_write_en) ram_log.push_back('{int'(ram_write_addr), int'(ram_write_data), cyc});
            if (link_write_en) link_log.push_back('{int'(link_write_addr), int'(link_write_data)});
            if (data_table_write_req) dt_log.push_back(int'(data_table_write_addr));
            if (pkt_done) done_n = done_n + 1;
            if (free_table_read_req && free_table_empty) bad_pop_n = bad_pop_n + 1;
        end
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("[TB] ok %s = %0d", name, act);
        end
    endtask

    task automatic ft_reload(input int pg[$]);
        ft_resync_to = ft_tail;
        foreach (pg[i]) begin
            ft_pages[ft_tail] = 4'(pg[i]);
            ft_tail = ft_tail + 8'd1;
        end
        ft_resync = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ft_resync = 1'b0;
    endtask

    task automatic ft_append(input int page);
        ft_pages[ft_tail] = 4'(page);
        ft_tail = ft_tail + 8'd1;
    endtask

    // Called at a negedge; returns at a negedge with in_valid low.
    task automatic send_words(input int words[$], input int gap_pct, input bit last_en);
        int idx = 0;
        int guard = 0;
        bit acc;
        while (idx < words.size()) begin
            if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_data  = DW'(words[idx]);
                in_last  = last_en && (idx == words.size() - 1);
            end
            acc = in_valid && in_ready;
            @(posedge clk);
            @(negedge clk);
            if (acc) idx++;
            guard++;
            if (guard > 500) begin
                check("send_timeout", idx, words.size());
                break;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int guard = 0;
        while (done_n < target && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (done_n < target) check("done_timeout", done_n, target);
        @(negedge clk);
    endtask

    // Reference: word i of a packet lands at page pages[i/PW], offset i%PW;
    // consecutive pages are chained and the last page points to itself.
    task automatic verify(input string nm, input int words[$], input int pages[$],
                          input int rb, input int lb, input int db, input int pb);
        int n   = words.size();
        int npg = (n + PW - 1) / PW;
        check({nm, " ram_writes"}, ram_log.size() - rb, n);
        for (int i = 0; i < n; i++) begin
            if (rb + i < ram_log.size()) begin
                check($sformatf("%s ram_addr[%0d]", nm, i), ram_log[rb+i].addr,
                      pages[i/PW] * PW + i % PW);
                check($sformatf("%s ram_data[%0d]", nm, i), ram_log[rb+i].data, words[i]);
            end
        end
        check({nm, " link_writes"}, link_log.size() - lb, npg);
        for (int k = 0; k < npg; k++) begin
            if (lb + k < link_log.size()) begin
                check($sformatf("%s link_a[%0d]", nm, k), link_log[lb+k].a, pages[k]);
                check($sformatf("%s link_d[%0d]", nm, k), link_log[lb+k].d,
                      (k == npg - 1) ? pages[k] : pages[k+1]);
            end
        end
        check({nm, " dt_writes"}, dt_log.size() - db, 1);
        if (db < dt_log.size()) check({nm, " dt_head"}, dt_log[db], pages[0]);
        check({nm, " pops"}, pops - pb, npg);
        check({nm, " pkt_word_cnt"}, int'(pkt_word_cnt), n);
    endtask

    typedef struct {
        int len;
        int data0;
        int exp_pops;
        int exp_links;
        int exp_cnt;
        int exp_head;
    } vec_t;

    vec_t vt[3];

    task automatic check_all_zero(input string nm);
        check({nm, " in_ready"}, int'(in_ready), 0);
        check({nm, " outputs"}, int'({free_table_read_req, data_table_write_req,
              data_table_write_addr, ram_write_en, ram_write_addr, link_write_en,
              link_write_addr, link_write_data, pkt_done}), 0);
        check({nm, " pkt_word_cnt"}, int'(pkt_word_cnt), 0);
    endtask

    initial begin
        int pl[$];
        int wq[$];
        int perm[$];
        int rb, lb, db, pb, d0, p0, l0;
        bit stall_ok;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        vt[0] = '{1, 16'hA5A5, 1, 1, 1, 3};
        vt[1] = '{4, 16'h1000, 1, 1, 4, 3};
        vt[2] = '{6, 16'h2000, 2, 2, 6, 3};

        for (int t = 0; t < 3; t++) begin
            pl = '{3, 7, 9};
            ft_reload(pl);
            wq.delete();
            for (int i = 0; i < vt[t].len; i++) wq.push_back(vt[t].data0 + i);
            rb = ram_log.size(); lb = link_log.size(); db = dt_log.size();
            pb = pops; d0 = done_n;
            send_words(wq, 0, 1'b1);
            wait_done(d0 + 1);
            check($sformatf("vec%0d pops", t), pops - pb, vt[t].exp_pops);
            check($sformatf("vec%0d links", t), link_log.size() - lb, vt[t].exp_links);
            check($sformatf("vec%0d cnt", t), int'(pkt_word_cnt), vt[t].exp_cnt);
            if (db < dt_log.size()) check($sformatf("vec%0d head", t), dt_log[db], vt[t].exp_head);
            verify($sformatf("vec%0d", t), wq, pl, rb, lb, db, pb);
        end

        // Free table runs dry after the first page; writer must stall in NEXT.
        pl = '{3};
        ft_reload(pl);
        wq = '{16'h5000, 16'h5001, 16'h5002, 16'h5003, 16'h5004};
        rb = ram_log.size(); lb = link_log.size(); db = dt_log.size();
        pb = pops; d0 = done_n;
        fork
            send_words(wq, 0, 1'b1);
            begin
                int g = 0;
                while (ram_log.size() < rb + 4 && g < 100) begin
                    @(posedge clk);
                    g++;
                end
                p0 = pops; l0 = link_log.size();
                stall_ok = 1'b1;
                repeat (10) begin
                    @(negedge clk);
                    if (in_ready || link_write_en || free_table_read_req) stall_ok = 1'b0;
                end
                check("stall quiet", int'(stall_ok), 1);
                check("stall no_pop", pops - p0, 0);
                check("stall no_link", link_log.size() - l0, 0);
                ft_append(7);
            end
        join
        wait_done(d0 + 1);
        pl = '{3, 7};
        verify("stall", wq, pl, rb, lb, db, pb);

        // Reset in the middle of a packet abandons it.
        pl = '{3, 7, 9};
        ft_reload(pl);
        wq = '{16'h6000, 16'h6001};
        db = dt_log.size();
        send_words(wq, 0, 1'b0);
        rst = 1'b1;
        in_data = '0;
        @(posedge clk);
        @(negedge clk);
        check_all_zero("midrst");
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("midrst no_dt", dt_log.size() - db, 0);
        wq = '{16'h7777};
        rb = ram_log.size(); lb = link_log.size(); db = dt_log.size();
        pb = pops; d0 = done_n;
        send_words(wq, 0, 1'b1);
        wait_done(d0 + 1);
        pl = '{7, 9};
        verify("postrst", wq, pl, rb, lb, db, pb);

        // Back-to-back single-word packets with in_valid held high.
        pl = '{3, 7};
        ft_reload(pl);
        rb = ram_log.size(); db = dt_log.size(); d0 = done_n;
        wq = '{16'h0101};
        send_words(wq, 0, 1'b1);
        wq = '{16'h0202};
        send_words(wq, 0, 1'b1);
        wait_done(d0 + 2);
        check("b2b ram_writes", ram_log.size() - rb, 2);
        check("b2b dt_writes", dt_log.size() - db, 2);
        if (ram_log.size() >= rb + 2) begin
            check("b2b spacing", ram_log[rb+1].cyc - ram_log[rb].cyc, 3);
            check("b2b addr0", ram_log[rb].addr, 3 * PW);
            check("b2b addr1", ram_log[rb+1].addr, 7 * PW);
        end
        if (dt_log.size() >= db + 2) begin
            check("b2b head0", dt_log[db], 3);
            check("b2b head1", dt_log[db+1], 7);
        end

        // Randomized packets with random page order and input gaps.
        for (int r = 0; r < 20; r++) begin
            int len;
            perm.delete();
            for (int i = 0; i < 16; i++) perm.push_back(i);
            perm.shuffle();
            pl.delete();
            for (int i = 0; i < 4; i++) pl.push_back(perm[i]);
            ft_reload(pl);
            len = $urandom_range(1, 13);
            wq.delete();
            for (int i = 0; i < len; i++) wq.push_back(int'($urandom_range(0, 16'hFFFF)));
            rb = ram_log.size(); lb = link_log.size(); db = dt_log.size();
            pb = pops; d0 = done_n;
            send_words(wq, 30, 1'b1);
            wait_done(d0 + 1);
            verify($sformatf("rnd%0d", r), wq, pl, rb, lb, db, pb);
        end

        check("pop_while_empty", bad_pop_n, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
